narrow_seq_multiplier: RTL and testbench

- Sequential, parametrised successor to the combinational narrow array multiplier.
- Produces a 2*WIDTH-bit product by consuming DIGIT multiplier bits per clock, so only one WIDTH x DIGIT partial-product array is needed.
- Adds a valid/ready handshake on both sides and a per-operation signed/unsigned mode.
- Sits between operand producers and result consumers in the datapath, trading latency for area.

---
 rtl/narrow_seq_multiplier.sv | 180 ++++++++++++++++++
 tb/tb_narrow_seq_multiplier.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/narrow_seq_multiplier.sv
// rtl/narrow_seq_multiplier.sv - digit-serial WIDTH x WIDTH multiplier with valid/ready handshake and signed/unsigned mode
// Optional macro: NARROW_SEQ_MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module narrow_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Number of BUSY cycles for a full-length operation and the matching counter width.
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int AW    = 2 * WIDTH + DIGIT;

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_is_signed;
    logic [AW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH+DIGIT-1:0] w_pp;
    logic [AW-1:0]        w_sum;
    logic [AW-1:0]        w_acc_step;
    logic [AW-1:0]        w_acc_final;
    logic [WIDTH-1:0]     w_b_shift;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_last;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_result;
    logic [DIGIT-1:0]     w_unused_acc_top;

    // Operand magnitudes at accept time; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        w_abs_a = a;
        w_abs_b = b;
        if (is_signed && a[WIDTH-1]) begin
            w_abs_a = (~a) + ONE_W;
        end
        if (is_signed && b[WIDTH-1]) begin
            w_abs_b = (~b) + ONE_W;
        end
    end

    // One digit step: partial product into the top of the accumulator, then shift everything right by DIGIT.
    always_comb begin
        w_pp       = {{DIGIT{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, r_mag_b[DIGIT-1:0]};
        w_sum      = r_acc + {w_pp, {WIDTH{1'b0}}};
        w_acc_step = w_sum >> DIGIT;
        w_b_shift  = r_mag_b >> DIGIT;
        w_cnt_next = r_cnt + CW'(1);
`ifdef NARROW_SEQ_MUL_EARLY_TERM_EN
        // Stopping early skips the remaining shifts, so apply them all at once to keep the product aligned.
        w_last      = (w_cnt_next == CW'(STEPS)) || (w_b_shift == '0);
        w_acc_final = w_acc_step >> ((STEPS - int'(w_cnt_next)) * DIGIT);
`else
        w_last      = (w_cnt_next == CW'(STEPS));
        w_acc_final = w_acc_step;
`endif
    end

    // Sign restoration of the unsigned magnitude product; the top DIGIT accumulator bits are always zero here.
    always_comb begin
        w_neg            = r_is_signed & (r_sign_a ^ r_sign_b);
        w_unused_acc_top = w_acc_final[AW-1:2*WIDTH];
        if (w_neg) begin
            w_result = (~w_acc_final[2*WIDTH-1:0]) + ONE_2W;
        end else begin
            w_result = w_acc_final[2*WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, step the accumulator in BUSY, capture the product on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_is_signed <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag_a     <= w_abs_a;
                        r_mag_b     <= w_abs_b;
                        r_sign_a    <= a[WIDTH-1];
                        r_sign_b    <= b[WIDTH-1];
                        r_is_signed <= is_signed;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_step;
                    r_mag_b <= w_b_shift;
                    r_cnt   <= w_cnt_next;
                    if (w_last) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_narrow_seq_multiplier.sv
// tb/tb_narrow_seq_multiplier.sv - scoreboard bench for narrow_seq_multiplier at WIDTH=32, DIGIT=4
module tb_narrow_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    narrow_seq_multiplier #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Reference: multiply the sign- or zero-extended operands modulo 2^64.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = s ? {{32{x[31]}}, x} : {32'b0, x};
        ey = s ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    function automatic logic [63:0] pop_exp();
        if (sb.size() == 0) return 64'hDEAD_DEAD_DEAD_DEAD;
        return sb.pop_front();
    endfunction

    // Runs one operation: pushes the expectation, counts edges from accept (inclusive) to out_valid, then handshakes.
    task automatic drive_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                            output logic [63:0] prod, output int edges, output int rdy_bad);
        int n;
        prod = '0;
        rdy_bad = 0;
        a = ta; b = tbv; is_signed = ts; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        sb.push_back(model(ta, tbv, ts));
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
        edges = 1;
        if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
        while (out_valid !== 1'b1 && edges < 200) begin
            @(posedge clk); #1; edges++;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
        end
        prod = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic();
        logic [63:0] p, e; int ed, rb;
        drive_op(32'h3, 32'h5, 1'b0, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL basic_product got %h want %h", p, e); end
        checks++; if (ed !== 9) begin errors++; $display("FAIL basic_latency got %0d edges want 9", ed); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL basic_in_ready_busy got %0d bad cycles want 0", rb); end
    endtask

    task automatic test_unsigned_max();
        logic [63:0] p, e; int ed, rb;
        drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL umax_product got %h want %h", p, e); end
        checks++; if (ed !== 9) begin errors++; $display("FAIL umax_latency got %0d want 9", ed); end
    endtask

    task automatic test_signed();
        logic [31:0] ta[7] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] tv[7] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'h0000_0001, 32'h0000_0002, 32'h0001_2345};
        logic        tsg[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] p, e; int ed, rb;
        for (int i = 0; i < 7; i++) begin
            drive_op(ta[i], tv[i], tsg[i], p, ed, rb);
            e = pop_exp();
            checks++; if (p !== e) begin errors++; $display("FAIL signed_product[%0d] got %h want %h", i, p, e); end
            checks++; if (ed !== 9) begin errors++; $display("FAIL signed_latency[%0d] got %0d want 9", i, ed); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e; int n;
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        sb.push_back(model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
        @(posedge clk); #1;
        a = 32'h0000_0002; b = 32'h0000_0002; is_signed = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        e = pop_exp();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (product !== e) begin errors++; $display("FAIL bp_product[%0d] got %h want %h", i, product, e); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++; if (product !== e) begin errors++; $display("FAIL bp_release_product got %h want %h", product, e); end
    endtask

    task automatic test_reset_mid_busy();
        logic [63:0] p, e; int ed, rb, n;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; is_signed = 1'b0; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        checks++; if (product !== 64'd0) begin errors++; $display("FAIL midrst_product got %h want 0", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        drive_op(32'd6, 32'd7, 1'b0, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL midrst_next_product got %h want %h", p, e); end
        checks++; if (ed !== 9) begin errors++; $display("FAIL midrst_next_latency got %0d want 9", ed); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int cyc = 0;
        int n_acc = 0;
        int n_out = 0;
        logic [31:0] ta, tv;
        logic ts, will_acc, will_out;
        logic [63:0] p, e;
        ta = $urandom; tv = $urandom; ts = 1'($urandom);
        a = ta; b = tv; is_signed = ts; in_valid = 1'b1; out_ready = 1'b1;
        while (n_out < 4 && cyc < 300) begin
            will_acc = in_valid && in_ready;
            will_out = out_valid && out_ready;
            p = product;
            @(posedge clk); #1; cyc++;
            if (will_acc) begin
                sb.push_back(model(ta, tv, ts));
                acc_cyc.push_back(cyc);
                n_acc++;
                ta = $urandom; tv = $urandom; ts = 1'($urandom);
                a = ta; b = tv; is_signed = ts;
                if (n_acc == 4) in_valid = 1'b0;
            end
            if (will_out) begin
                e = pop_exp();
                n_out++;
                checks++; if (p !== e) begin errors++; $display("FAIL b2b_product[%0d] got %h want %h", n_out, p, e); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (n_out !== 4) begin errors++; $display("FAIL b2b_count got %0d results want 4", n_out); end
        for (int i = 0; i + 1 < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] !== 10) begin
                errors++; $display("FAIL b2b_spacing[%0d] got %0d cycles want 10", i, acc_cyc[i+1] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_early_term();
        logic [63:0] p, e; int ed, rb;
        drive_op(32'hCAFE_1234, 32'h0000_0001, 1'b0, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL et_b1_product got %h want %h", p, e); end
`ifdef NARROW_SEQ_MUL_EARLY_TERM_EN
        checks++; if (ed !== 2) begin errors++; $display("FAIL et_b1_latency got %0d want 2", ed); end
`else
        checks++; if (ed !== 9) begin errors++; $display("FAIL et_b1_latency got %0d want 9", ed); end
`endif
        drive_op(32'h0000_0005, 32'h1000_0000, 1'b0, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL et_btop_product got %h want %h", p, e); end
        checks++; if (ed !== 9) begin errors++; $display("FAIL et_btop_latency got %0d want 9", ed); end
        drive_op(32'hFFFF_FFF0, 32'h0000_0000, 1'b1, p, ed, rb);
        e = pop_exp();
        checks++; if (p !== e) begin errors++; $display("FAIL et_b0_product got %h want %h", p, e); end
`ifdef NARROW_SEQ_MUL_EARLY_TERM_EN
        checks++; if (ed !== 2) begin errors++; $display("FAIL et_b0_latency got %0d want 2", ed); end
`else
        checks++; if (ed !== 9) begin errors++; $display("FAIL et_b0_latency got %0d want 9", ed); end
`endif
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_early_term();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
